// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch program-counter unit: FSM states, redirect sources
// and the alignment helper.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Encoding order is the redirect priority order.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redirect_src_e;

    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned ialign);
        return (addr & (64'(ialign) - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Valid/ready fetch request channel between the PC unit and instruction memory.
interface pc_fetch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;

    modport master (output req_valid, output req_addr, input  req_ready);
    modport slave  (input  req_valid, input  req_addr, output req_ready);
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: trap > jump_reg > branch, target formation
// and alignment check of the winning target.
module pc_redirect_arb
    import pc_fetch_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_imm,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic            valid,
    output redirect_src_e   src,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    always_comb begin
        valid  = 1'b0;
        src    = NONE;
        target = '0;
        if (trap) begin
            valid  = 1'b1;
            src    = TRAP;
            target = trap_vector & ~ALIGN_MASK;
        end else if (jump_reg) begin
            valid  = 1'b1;
            src    = JUMP;
            target = jump_target & ~XLEN'(1);
        end else if (branch_taken) begin
            valid  = 1'b1;
            src    = BRANCH;
            target = pc + branch_imm;
        end
    end

    // Trap targets are masked, so a trap can never be flagged here.
    assign misaligned = valid && !is_aligned(64'(target), IALIGN);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: owns the PC, issues valid/ready fetch requests,
// buffers one redirect across memory stalls and halts on misaligned targets.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     IALIGN       = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    branch_taken,
    input  logic [XLEN-1:0]         branch_imm,
    input  logic                    jump_reg,
    input  logic [XLEN-1:0]         jump_target,
    input  logic                    trap,
    input  logic [XLEN-1:0]         trap_vector,
    pc_fetch_ctrl_if.master         req,
    output logic [XLEN-1:0]         pc_out,
    output logic [XLEN-1:0]         pc_plus_inc,
    output logic                    redirect_pending,
    output logic                    misaligned
);

    state_e          state, state_next;
    logic [XLEN-1:0] pc_next;
    logic            pend_valid_next;
    redirect_src_e   pend_src, pend_src_next;
    logic [XLEN-1:0] pend_target, pend_target_next;
    logic            misaligned_next;
    logic            req_valid_q;

    logic            arb_valid;
    redirect_src_e   arb_src;
    logic [XLEN-1:0] arb_target;
    logic            arb_misaligned;

    logic            accept;
    logic            update;

    pc_redirect_arb #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_arb (
        .pc           (pc_out),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_reg     (jump_reg),
        .jump_target  (jump_target),
        .trap         (trap),
        .trap_vector  (trap_vector),
        .valid        (arb_valid),
        .src          (arb_src),
        .target       (arb_target),
        .misaligned   (arb_misaligned)
    );

    assign accept      = (state == REQ) && req.req_ready;
    assign update      = (state == IDLE) || accept;
    assign pc_plus_inc = pc_out + XLEN'(INC);

    assign req.req_valid = req_valid_q;
    assign req.req_addr  = pc_out;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            pc_out           <= RESET_VECTOR;
            redirect_pending <= 1'b0;
            pend_src         <= NONE;
            pend_target      <= '0;
            misaligned       <= 1'b0;
            req_valid_q      <= 1'b0;
        end else begin
            state            <= state_next;
            pc_out           <= pc_next;
            redirect_pending <= pend_valid_next;
            pend_src         <= pend_src_next;
            pend_target      <= pend_target_next;
            misaligned       <= misaligned_next;
            req_valid_q      <= (state_next == REQ);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_misaligned) state_next = HALT;
                else if (en)        state_next = REQ;
            end
            REQ: begin
                if (arb_misaligned) state_next = HALT;
                else if (accept)    state_next = en ? REQ : IDLE;
            end
            HALT: begin
                if (trap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // PC, pending-buffer and sticky-flag update.
    always_comb begin
        pc_next          = pc_out;
        pend_valid_next  = redirect_pending;
        pend_src_next    = pend_src;
        pend_target_next = pend_target;
        misaligned_next  = misaligned;
        if (state == HALT) begin
            if (trap) begin
                pc_next         = arb_target;
                misaligned_next = 1'b0;
            end
        end else if (arb_misaligned) begin
            misaligned_next = 1'b1;
            pend_valid_next = 1'b0;
            pend_src_next   = NONE;
        end else if (update) begin
            pend_valid_next = 1'b0;
            pend_src_next   = NONE;
            if (arb_valid)             pc_next = arb_target;
            else if (redirect_pending) pc_next = pend_target;
            else if (accept)           pc_next = pc_plus_inc;
        end else if (arb_valid && (!redirect_pending || arb_src >= pend_src)) begin
            // Stalled request: hold the address, remember the redirect.
            pend_valid_next  = 1'b1;
            pend_src_next    = arb_src;
            pend_target_next = arb_target;
        end
    end

endmodule
